axis_frame_gen: RTL and testbench

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

---
 rtl/axis_frame_gen_pkg.sv | 16 +
 rtl/axis_frame_gen_if.sv | 31 +++
 rtl/axis_frame_gen.sv | 134 +++++++++++++
 tb/tb_axis_frame_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_gen_pkg.sv
// Shared AXIS definitions: default stream widths and the frame generator FSM state type.
package axis_frame_gen_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 8;
  localparam int unsigned AXIS_LEN_WIDTH  = 16;
  localparam int unsigned AXIS_ID_WIDTH   = 8;
  localparam int unsigned AXIS_DEST_WIDTH = 8;
  localparam int unsigned AXIS_USER_WIDTH = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle with master (transmitter) and slave (receiver) views.
interface ifc_axis
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int unsigned ID_WIDTH   = AXIS_ID_WIDTH,
  parameter int unsigned DEST_WIDTH = AXIS_DEST_WIDTH,
  parameter int unsigned USER_WIDTH = AXIS_USER_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tvalid, tlast, tkeep, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tkeep, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: emits one frame of incrementing bytes (seed + i) per accepted start.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int unsigned LEN_WIDTH  = AXIS_LEN_WIDTH,
  parameter int unsigned ID_WIDTH   = AXIS_ID_WIDTH,
  parameter int unsigned DEST_WIDTH = AXIS_DEST_WIDTH,
  parameter int unsigned USER_WIDTH = AXIS_USER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [7:0]            seed,
  input  logic [ID_WIDTH-1:0]   cfg_tid,
  input  logic [DEST_WIDTH-1:0] cfg_tdest,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frame_cnt,
  ifc_axis.master               m_axis_ifc
);

  fsm_state_t state, state_nxt;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  off_q;
  logic [7:0]            seed_q;
  logic [ID_WIDTH-1:0]   tid_q;
  logic [DEST_WIDTH-1:0] tdest_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  tlast_q;
  logic                  tvalid_q;

  logic accept_c;
  logic hs_c;
  logic last_hs_c;
  logic load_c;

  logic [LEN_WIDTH-1:0]  calc_off;
  logic [LEN_WIDTH-1:0]  calc_len;
  logic [7:0]            calc_seed;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] calc_data;
  logic [KEEP_WIDTH-1:0] calc_keep;
  logic                  calc_last;

  assign accept_c  = (state == IDLE) && start && (len != '0);
  assign hs_c      = tvalid_q && m_axis_ifc.tready;
  assign last_hs_c = hs_c && tlast_q;
  // A new beat is loaded on frame start or when a non-final beat is consumed.
  assign load_c    = accept_c || (hs_c && !tlast_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept_c) state_nxt = SEND;
      SEND:    if (last_hs_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next-beat payload: the first beat comes straight from the start inputs, later ones from captured config.
  always_comb begin
    calc_off  = accept_c ? '0   : off_q + LEN_WIDTH'(KEEP_WIDTH);
    calc_len  = accept_c ? len  : len_q;
    calc_seed = accept_c ? seed : seed_q;
    remaining = calc_len - calc_off;
    calc_last = (remaining <= LEN_WIDTH'(KEEP_WIDTH));
    calc_data = '0;
    calc_keep = '0;
    for (int unsigned j = 0; j < KEEP_WIDTH; j++) begin
      if (LEN_WIDTH'(j) < remaining) begin
        calc_keep[j]       = 1'b1;
        calc_data[j*8 +: 8] = calc_seed + 8'(calc_off) + 8'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      off_q     <= '0;
      seed_q    <= '0;
      tid_q     <= '0;
      tdest_q   <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (accept_c) begin
        len_q   <= len;
        seed_q  <= seed;
        tid_q   <= cfg_tid;
        tdest_q <= cfg_tdest;
      end
      if (load_c) begin
        off_q   <= calc_off;
        tdata_q <= calc_data;
        tkeep_q <= calc_keep;
        tlast_q <= calc_last;
      end else if (last_hs_c) begin
        tdata_q <= '0;
        tkeep_q <= '0;
        tlast_q <= 1'b0;
      end
      tvalid_q <= (state_nxt == SEND);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      if (last_hs_c) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  assign m_axis_ifc.tdata  = tdata_q;
  assign m_axis_ifc.tvalid = tvalid_q;
  assign m_axis_ifc.tlast  = tlast_q;
  assign m_axis_ifc.tkeep  = tkeep_q;
  assign m_axis_ifc.tid    = tid_q;
  assign m_axis_ifc.tdest  = tdest_q;
  assign m_axis_ifc.tuser  = {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: a 32-bit and an 8-bit instance sharing clock and reset.
module tb_axis_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, start8;
  logic [15:0] len32, len8;
  logic [7:0]  seed32, seed8;
  logic [7:0]  tid32, tdest32, tid8, tdest8;
  logic        busy32, done32, busy8, done8;
  logic [31:0] cnt32, cnt8;

  int n_assert = 0;
  int n_fail   = 0;

  ifc_axis #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) ax32 ();
  ifc_axis #(.DATA_WIDTH(8),  .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) ax8 ();

  axis_frame_gen #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .LEN_WIDTH(16)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .len(len32), .seed(seed32),
    .cfg_tid(tid32), .cfg_tdest(tdest32), .busy(busy32), .done(done32),
    .frame_cnt(cnt32), .m_axis_ifc(ax32)
  );

  axis_frame_gen #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .LEN_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .len(len8), .seed(seed8),
    .cfg_tid(tid8), .cfg_tdest(tdest8), .busy(busy8), .done(done8),
    .frame_cnt(cnt8), .m_axis_ifc(ax8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [31:0] exp_d [3];
  logic [3:0]  exp_k [3];
  logic        exp_l [3];
  logic [7:0]  first_b [3];
  logic        saw_done, saw_valid, finished;
  int          beats, derr, kerr, lerr;

  initial begin
    exp_d[0] = 32'hF3F2F1F0; exp_k[0] = 4'hF; exp_l[0] = 1'b0;
    exp_d[1] = 32'hF7F6F5F4; exp_k[1] = 4'hF; exp_l[1] = 1'b0;
    exp_d[2] = 32'h0000F9F8; exp_k[2] = 4'h3; exp_l[2] = 1'b1;

    rst = 1'b1;
    start32 = 1'b0; len32 = '0; seed32 = '0; tid32 = '0; tdest32 = '0; ax32.tready = 1'b0;
    start8  = 1'b0; len8  = '0; seed8  = '0; tid8  = '0; tdest8  = '0; ax8.tready  = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_tvalid", 64'(ax32.tvalid), 64'd0);
    check("rst_tlast",  64'(ax32.tlast),  64'd0);
    check("rst_busy",   64'(busy32),      64'd0);
    check("rst_done",   64'(done32),      64'd0);
    check("rst_cnt",    64'(cnt32),       64'd0);
    check("rst_tdata",  64'(ax32.tdata),  64'd0);
    check("rst_tkeep",  64'(ax32.tkeep),  64'd0);
    check("rst_tid",    64'(ax32.tid),    64'd0);
    check("rst_tdest",  64'(ax32.tdest),  64'd0);
    check("rst_tuser",  64'(ax32.tuser),  64'd0);
    check("rst8_tvalid", 64'(ax8.tvalid), 64'd0);
    rst = 1'b0;
    step();

    // len=10 seed=F0, tready high; inputs scrambled after start
    start32 = 1'b1; len32 = 16'd10; seed32 = 8'hF0; tid32 = 8'h5A; tdest32 = 8'h3C; ax32.tready = 1'b1;
    step();
    start32 = 1'b0; len32 = 16'd4; seed32 = 8'h00; tid32 = 8'h00; tdest32 = 8'h00;
    check("f1_tid",   64'(ax32.tid),   64'h5A);
    check("f1_tdest", 64'(ax32.tdest), 64'h3C);
    check("f1_tuser", 64'(ax32.tuser), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("f1_tvalid%0d", k), 64'(ax32.tvalid), 64'd1);
      check($sformatf("f1_tdata%0d", k),  64'(ax32.tdata),  64'(exp_d[k]));
      check($sformatf("f1_tkeep%0d", k),  64'(ax32.tkeep),  64'(exp_k[k]));
      check($sformatf("f1_tlast%0d", k),  64'(ax32.tlast),  64'(exp_l[k]));
      check($sformatf("f1_busy%0d", k),   64'(busy32),      64'd1);
      step();
    end
    check("f1_end_tvalid", 64'(ax32.tvalid), 64'd0);
    check("f1_done",       64'(done32),      64'd1);
    check("f1_done_busy",  64'(busy32),      64'd1);
    check("f1_cnt",        64'(cnt32),       64'd1);
    step();
    check("f1_done_off", 64'(done32), 64'd0);
    check("f1_idle",     64'(busy32), 64'd0);

    // len=8 with tready toggling
    start32 = 1'b1; len32 = 16'd8; seed32 = 8'h10;
    step();
    start32 = 1'b0;
    check("f2_b0",       64'(ax32.tdata), 64'h13121110);
    check("f2_b0_last",  64'(ax32.tlast), 64'd0);
    ax32.tready = 1'b0;
    step();
    check("f2_b0_hold",  64'(ax32.tdata),  64'h13121110);
    check("f2_b0_valid", 64'(ax32.tvalid), 64'd1);
    ax32.tready = 1'b1;
    step();
    check("f2_b1",       64'(ax32.tdata), 64'h17161514);
    check("f2_b1_keep",  64'(ax32.tkeep), 64'hF);
    check("f2_b1_last",  64'(ax32.tlast), 64'd1);
    ax32.tready = 1'b0;
    step();
    check("f2_b1_hold",  64'(ax32.tdata),  64'h17161514);
    check("f2_b1_hvld",  64'(ax32.tvalid), 64'd1);
    check("f2_b1_hlast", 64'(ax32.tlast),  64'd1);
    ax32.tready = 1'b1;
    step();
    check("f2_end_tvalid", 64'(ax32.tvalid), 64'd0);
    check("f2_done",       64'(done32),      64'd1);
    check("f2_cnt",        64'(cnt32),       64'd2);
    step();

    // len=0 start, start while busy, start during DONE
    start32 = 1'b1; len32 = 16'd0;
    step();
    start32 = 1'b0;
    check("z_tvalid", 64'(ax32.tvalid), 64'd0);
    check("z_busy",   64'(busy32),      64'd0);
    start32 = 1'b1; len32 = 16'd8; seed32 = 8'h20; ax32.tready = 1'b0;
    step();
    check("b_b0", 64'(ax32.tdata), 64'h23222120);
    start32 = 1'b1; len32 = 16'd4; seed32 = 8'h99;
    step();
    check("b_b0_hold", 64'(ax32.tdata), 64'h23222120);
    check("b_busy",    64'(busy32),     64'd1);
    start32 = 1'b0; ax32.tready = 1'b1;
    step();
    check("b_b1",      64'(ax32.tdata), 64'h27262524);
    check("b_b1_last", 64'(ax32.tlast), 64'd1);
    step();
    check("b_done", 64'(done32), 64'd1);
    check("b_cnt",  64'(cnt32),  64'd3);
    start32 = 1'b1; len32 = 16'd4; seed32 = 8'h99;
    step();
    start32 = 1'b0;
    check("d_ign_tvalid", 64'(ax32.tvalid), 64'd0);
    check("d_ign_busy",   64'(busy32),      64'd0);
    step();
    check("d_ign_tvalid2", 64'(ax32.tvalid), 64'd0);
    check("d_ign_cnt",     64'(cnt32),       64'd3);

    // back-to-back single-beat frames
    start32 = 1'b1; len32 = 16'd4; seed32 = 8'h40;
    step();
    start32 = 1'b0;
    check("bb1_data", 64'(ax32.tdata), 64'h43424140);
    check("bb1_last", 64'(ax32.tlast), 64'd1);
    check("bb1_keep", 64'(ax32.tkeep), 64'hF);
    step();
    check("bb_gap1",  64'(ax32.tvalid), 64'd0);
    check("bb1_done", 64'(done32),      64'd1);
    check("bb1_cnt",  64'(cnt32),       64'd4);
    step();
    check("bb_gap2", 64'(ax32.tvalid), 64'd0);
    start32 = 1'b1; len32 = 16'd4; seed32 = 8'h50;
    step();
    start32 = 1'b0;
    check("bb2_tvalid", 64'(ax32.tvalid), 64'd1);
    check("bb2_data",   64'(ax32.tdata),  64'h53525150);
    step();
    check("bb2_done", 64'(done32), 64'd1);
    check("bb2_cnt",  64'(cnt32),  64'd5);
    step();

    // reset mid-frame of a 4-beat frame
    start32 = 1'b1; len32 = 16'd16; seed32 = 8'h00;
    step();
    start32 = 1'b0;
    check("r_b0", 64'(ax32.tdata), 64'h03020100);
    step();
    check("r_b1", 64'(ax32.tdata), 64'h07060504);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_tvalid", 64'(ax32.tvalid), 64'd0);
    check("r_busy",   64'(busy32),      64'd0);
    check("r_tdata",  64'(ax32.tdata),  64'd0);
    check("r_cnt",    64'(cnt32),       64'd0);
    saw_done = 1'b0; saw_valid = 1'b0;
    repeat (6) begin
      step();
      if (done32) saw_done = 1'b1;
      if (ax32.tvalid) saw_valid = 1'b1;
    end
    check("r_no_done",  64'(saw_done),  64'd0);
    check("r_no_valid", 64'(saw_valid), 64'd0);
    check("r_cnt_after", 64'(cnt32),    64'd0);

    // 8-bit instance: len=300 seed=FF
    start8 = 1'b1; len8 = 16'd300; seed8 = 8'hFF; ax8.tready = 1'b1;
    step();
    start8 = 1'b0;
    beats = 0; derr = 0; kerr = 0; lerr = 0; finished = 1'b0;
    first_b[0] = '0; first_b[1] = '0; first_b[2] = '0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (done8) begin
        finished = 1'b1;
      end else begin
        if (ax8.tvalid) begin
          if (ax8.tdata !== 8'(8'hFF + beats)) derr++;
          if (ax8.tkeep !== 1'b1) kerr++;
          if (ax8.tlast !== (beats == 299)) lerr++;
          if (beats < 3) first_b[beats] = ax8.tdata;
          beats++;
        end
        step();
      end
    end
    check("w_finished", 64'(finished), 64'd1);
    check("w_beats",    64'(beats),    64'd300);
    check("w_data_err", 64'(derr),     64'd0);
    check("w_keep_err", 64'(kerr),     64'd0);
    check("w_last_err", 64'(lerr),     64'd0);
    check("w_byte0",    64'(first_b[0]), 64'hFF);
    check("w_byte1",    64'(first_b[1]), 64'h00);
    check("w_byte2",    64'(first_b[2]), 64'h01);
    check("w_cnt",      64'(cnt8),     64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
